// File: rtl/selectio_train_ctrl.sv
// SelectIO bring-up and word-alignment sequencer (clk_stream domain).
// Releases the clock-buffer reset, then the IO reset, and waits for IDELAYCTRL
// ready. It then bitslips until the training word holds for a run of words.
module selectio_train_ctrl #(
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] TRAIN_PATTERN  = 8'hF0,
  parameter int                CLK_RST_CYCLES = 16,
  parameter int                IO_RST_CYCLES  = 8,
  parameter int                SETTLE_CYCLES  = 32,
  parameter int                MATCH_COUNT    = 16,
  parameter int                MAX_SLIPS      = 8,
  parameter int                RDY_TIMEOUT    = 1024,
  parameter int                AUTO_START     = 1
) (
  input  logic              clk_stream,
  input  logic              rst_stream,
  input  logic              start,
  input  logic              idelay_rdy,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              sel_clk_rst,
  output logic              sel_io_rst,
  output logic              bitslip,
  output logic              busy,
  output logic              locked,
  output logic              fail,
  output logic [3:0]        slip_count
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared phase timer covers every timed state; it restarts on each entry.
  localparam int TMAX = imax(imax(CLK_RST_CYCLES, IO_RST_CYCLES), imax(SETTLE_CYCLES, RDY_TIMEOUT));
  localparam int TW   = $clog2(TMAX + 1);
  localparam int MW   = $clog2(MATCH_COUNT + 1);

  typedef enum logic [3:0] {
    IDLE, CLK_RST, IO_RST, WAIT_RDY, SETTLE, CHECK, SLIP, LOCKED, FAIL
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic [MW-1:0]   mcnt, mcnt_nx;
  logic [3:0]      slip_nx;
  logic            auto_pend;
  logic            clk_rst_nx, io_rst_nx, bitslip_nx, busy_nx, locked_nx, fail_nx;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    mcnt_nx  = mcnt;
    slip_nx  = slip_count;
    unique case (state)
      IDLE: begin
        if (start || auto_pend) begin
          state_nx = CLK_RST;
          tcnt_nx  = '0;
          slip_nx  = '0;
        end
      end
      CLK_RST: begin
        if (tcnt == TW'(CLK_RST_CYCLES - 1)) begin
          state_nx = IO_RST;
          tcnt_nx  = '0;
        end else tcnt_nx = tcnt + TW'(1);
      end
      IO_RST: begin
        if (tcnt == TW'(IO_RST_CYCLES - 1)) begin
          state_nx = WAIT_RDY;
          tcnt_nx  = '0;
        end else tcnt_nx = tcnt + TW'(1);
      end
      WAIT_RDY: begin
        if (idelay_rdy) begin
          state_nx = SETTLE;
          tcnt_nx  = '0;
        end else if (tcnt == TW'(RDY_TIMEOUT - 1)) begin
          state_nx = FAIL;
          tcnt_nx  = '0;
        end else tcnt_nx = tcnt + TW'(1);
      end
      SETTLE: begin
        if (tcnt == TW'(SETTLE_CYCLES - 1)) begin
          state_nx = CHECK;
          tcnt_nx  = '0;
          mcnt_nx  = '0;
        end else tcnt_nx = tcnt + TW'(1);
      end
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == TRAIN_PATTERN) begin
            mcnt_nx = mcnt + MW'(1);
            if (mcnt_nx == MW'(MATCH_COUNT)) state_nx = LOCKED;
          end else if (slip_count < 4'(MAX_SLIPS)) begin
            state_nx = SLIP;
            slip_nx  = (slip_count == 4'hF) ? slip_count : slip_count + 4'd1;
          end else begin
            state_nx = FAIL;
          end
        end
      end
      SLIP: begin
        state_nx = SETTLE;
        tcnt_nx  = '0;
      end
      LOCKED, FAIL: begin
        if (start) begin
          state_nx = CLK_RST;
          tcnt_nx  = '0;
          slip_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    clk_rst_nx = (state_nx == IDLE) || (state_nx == CLK_RST);
    io_rst_nx  = clk_rst_nx || (state_nx == IO_RST);
    bitslip_nx = (state_nx == SLIP);
    busy_nx    = !((state_nx == IDLE) || (state_nx == LOCKED) || (state_nx == FAIL));
    locked_nx  = (state_nx == LOCKED);
    fail_nx    = (state_nx == FAIL);
  end

  // State, counters and outputs; reset overrides everything.
  always_ff @(posedge clk_stream) begin
    if (rst_stream) begin
      state       <= IDLE;
      tcnt        <= '0;
      mcnt        <= '0;
      auto_pend   <= (AUTO_START != 0);
      sel_clk_rst <= 1'b1;
      sel_io_rst  <= 1'b1;
      bitslip     <= 1'b0;
      busy        <= 1'b0;
      locked      <= 1'b0;
      fail        <= 1'b0;
      slip_count  <= '0;
    end else begin
      state       <= state_nx;
      tcnt        <= tcnt_nx;
      mcnt        <= mcnt_nx;
      auto_pend   <= 1'b0;
      sel_clk_rst <= clk_rst_nx;
      sel_io_rst  <= io_rst_nx;
      bitslip     <= bitslip_nx;
      busy        <= busy_nx;
      locked      <= locked_nx;
      fail        <= fail_nx;
      slip_count  <= slip_nx;
    end
  end

endmodule

// File: tb/tb_selectio_train_ctrl.sv
// Bench for selectio_train_ctrl: timestamp-based phase model checked every
// cycle, plus hand-computed latencies and counts for each scenario.
module tb_selectio_train_ctrl;
  localparam logic [7:0] PAT = 8'hF0;
  localparam logic [9:0] RST_VEC = 10'h300;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, rdy = 1'b1, valid = 1'b1;
  logic [7:0] raw = 8'hF0;
  logic       use_slip = 1'b0, toggle = 1'b0;
  int         adc_slips = 0;
  logic [7:0] rx_data;
  logic       sel_clk_rst, sel_io_rst, bitslip, busy, locked, fail;
  logic [3:0] slip_count;

  int n_pass = 0, n_tot = 0, cyc = 0;
  bit cmp_en = 0;

  // ADC side: each bitslip rotates the delivered word right by one bit.
  function automatic logic [7:0] rotr(input logic [7:0] w, input int n);
    logic [7:0] r;
    r = w;
    for (int i = 0; i < n % 8; i++) r = {r[0], r[7:1]};
    return r;
  endfunction
  assign rx_data = use_slip ? rotr(raw, adc_slips) : raw;

  selectio_train_ctrl #(
    .DATA_W(8), .TRAIN_PATTERN(8'hF0), .CLK_RST_CYCLES(16), .IO_RST_CYCLES(8),
    .SETTLE_CYCLES(32), .MATCH_COUNT(16), .MAX_SLIPS(8), .RDY_TIMEOUT(1024), .AUTO_START(1)
  ) dut (
    .clk_stream(clk), .rst_stream(rst), .start(start), .idelay_rdy(rdy),
    .rx_valid(valid), .rx_data(rx_data), .sel_clk_rst(sel_clk_rst),
    .sel_io_rst(sel_io_rst), .bitslip(bitslip), .busy(busy), .locked(locked),
    .fail(fail), .slip_count(slip_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
  endtask

  // Model: phases with absolute end-cycle deadlines.
  localparam int P_IDLE = 0, P_CLK = 1, P_IO = 2, P_WAIT = 3, P_SET = 4,
                 P_CHK = 5, P_SLIP = 6, P_LOCK = 7, P_FAIL = 8;
  int m_ph = P_IDLE, m_until = 0, m_match = 0, m_slips = 0;
  bit m_auto = 1;

  task automatic m_launch();
    m_ph = P_CLK; m_until = cyc + 16; m_slips = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_slips = 0; m_auto = 1;
    end else begin
      case (m_ph)
        P_IDLE: if (m_auto || start) m_launch();
        P_CLK:  if (cyc == m_until) begin m_ph = P_IO; m_until = cyc + 8; end
        P_IO:   if (cyc == m_until) begin m_ph = P_WAIT; m_until = cyc + 1024; end
        P_WAIT: if (rdy) begin m_ph = P_SET; m_until = cyc + 32; end
                else if (cyc == m_until) m_ph = P_FAIL;
        P_SET:  if (cyc == m_until) begin m_ph = P_CHK; m_match = 0; end
        P_CHK:  if (valid) begin
                  if (rx_data == PAT) begin
                    m_match++;
                    if (m_match == 16) m_ph = P_LOCK;
                  end else if (m_slips < 8) begin
                    m_ph = P_SLIP; m_slips = (m_slips < 15) ? m_slips + 1 : 15;
                  end else m_ph = P_FAIL;
                end
        P_SLIP: begin m_ph = P_SET; m_until = cyc + 32; end
        default: if (start) m_launch();
      endcase
      m_auto = 0;
    end
  end

  function automatic logic [9:0] model_vec();
    return {m_ph <= P_CLK, m_ph <= P_IO, m_ph == P_SLIP, m_ph >= P_CLK && m_ph <= P_SLIP,
            m_ph == P_LOCK, m_ph == P_FAIL, 4'(m_slips)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {sel_clk_rst, sel_io_rst, bitslip, busy, locked, fail, slip_count};
  endfunction

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) if (cmp_en) chk("outputs", int'(dut_vec()), int'(model_vec()));

  // Edge timestamps and bitslip bookkeeping, refreshed on every tick.
  int  t_launch = 0, t_clk = 0, t_io = 0, t_lock = 0, t_fail = 0, n_pulse = 0;
  logic p_busy = 0, p_clk = 1, p_io = 1, p_lock = 0, p_fail = 0;

  task automatic tick();
    @(negedge clk);
    if (busy && !p_busy) begin t_launch = cyc; n_pulse = 0; end
    if (!sel_clk_rst && p_clk) t_clk = cyc;
    if (!sel_io_rst && p_io) t_io = cyc;
    if (locked && !p_lock) t_lock = cyc;
    if (fail && !p_fail) t_fail = cyc;
    if (bitslip) begin adc_slips++; n_pulse++; end
    if (rst) adc_slips = 0;
    if (toggle) valid = ~valid;
    p_busy = busy; p_clk = sel_clk_rst; p_io = sel_io_rst; p_lock = locked; p_fail = fail;
  endtask

  task automatic do_reset(input logic r_rdy, input logic [7:0] r_raw, input logic r_slip,
                          input logic r_tog);
    rst = 1; start = 0; rdy = r_rdy; raw = r_raw; use_slip = r_slip;
    toggle = r_tog; valid = 1;
    repeat (3) tick();
    cmp_en = 1;
    chk("reset_vals", int'(dut_vec()), int'(RST_VEC));
    rst = 0;
  endtask

  task automatic wait_sig(input int which, input int budget, input string nm);
    bit hit;
    int n;
    hit = 0; n = 0;
    while (!hit && n < budget) begin
      tick(); n++;
      case (which)
        0: hit = locked;
        1: hit = fail;
        default: hit = bitslip;
      endcase
    end
    chk(nm, int'(hit), 1);
  endtask

  initial begin
    // Clean pattern: auto launch and straight lock.
    do_reset(1'b1, PAT, 1'b0, 1'b0);
    wait_sig(0, 300, "lock_clean");
    chk("clk_rst_fall", t_clk - t_launch, 16);
    chk("io_rst_fall", t_io - t_launch, 24);
    chk("lock_latency", t_lock - t_launch, 73);
    chk("slips_clean", int'(slip_count), 0);
    chk("pulses_clean", n_pulse, 0);

    // Relaunch from LOCKED, plus an ignored start during CHECK.
    start = 1; tick(); start = 0;
    chk("relaunch_clkrst", int'(sel_clk_rst), 1);
    chk("relaunch_locked", int'(locked), 0);
    chk("relaunch_slips", int'(slip_count), 0);
    repeat (60) tick();
    start = 1; tick(); start = 0;
    wait_sig(0, 300, "relock");
    chk("relock_latency", t_lock - t_launch, 73);

    // Pattern rotated left by 3: three slips then lock.
    do_reset(1'b1, 8'h87, 1'b1, 1'b0);
    wait_sig(0, 500, "lock_rot3");
    chk("lock_rot3_latency", t_lock - t_launch, 175);
    chk("pulses_rot3", n_pulse, 3);
    chk("slips_rot3", int'(slip_count), 3);

    // Never-matching data: slip budget exhausted.
    do_reset(1'b1, 8'h00, 1'b0, 1'b0);
    wait_sig(1, 700, "fail_zero");
    chk("fail_zero_latency", t_fail - t_launch, 330);
    chk("pulses_zero", n_pulse, 8);
    chk("slips_zero", int'(slip_count), 8);
    chk("zero_locked", int'(locked), 0);
    chk("zero_busy", int'(busy), 0);

    // IDELAYCTRL never ready: timeout.
    do_reset(1'b0, PAT, 1'b0, 1'b0);
    wait_sig(1, 1300, "fail_rdy");
    chk("rdy_timeout_latency", t_fail - t_launch, 1048);
    chk("pulses_rdy", n_pulse, 0);

    // Reset asserted while a bitslip is being issued.
    do_reset(1'b1, 8'h87, 1'b1, 1'b0);
    wait_sig(2, 200, "see_slip");
    rst = 1; tick();
    chk("mid_reset_vals", int'(dut_vec()), int'(RST_VEC));
    repeat (2) tick();

    // rx_valid alternating: sixteen valid matches spread over ~32 cycles.
    do_reset(1'b1, PAT, 1'b0, 1'b1);
    wait_sig(0, 300, "lock_toggle");
    chk("toggle_latency_ok", int'((t_lock - t_launch == 88) || (t_lock - t_launch == 89)), 1);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/selectio_train_ctrl.md
Name: selectio_train_ctrl

Overview:
Sequences bring-up and word alignment of the ADC input SelectIO (ISERDES/IDELAY) in the clk_stream domain. Steps:
- Releases the clock-buffer reset, then the IO reset.
- Waits for IDELAYCTRL ready.
- Issues bitslip pulses until the deserialised training word matches a fixed pattern for a run of consecutive words.
- Reports locked or fail to the control logic.

Parameters:
DATA_W, 8, deserialised word width
TRAIN_PATTERN, 8'hF0, expected ADC training word (DATA_W bits)
CLK_RST_CYCLES, 16, cycles both SelectIO resets are held after launch
IO_RST_CYCLES, 8, cycles sel_io_rst is held after sel_clk_rst drops
SETTLE_CYCLES, 32, wait after ready (and after each bitslip) before checking
MATCH_COUNT, 16, consecutive matching valid words needed for lock
MAX_SLIPS, 8, bitslips allowed before fail (at most 15)
RDY_TIMEOUT, 1024, cycles allowed for idelay_rdy
AUTO_START, 1, 1 = launch training on the first cycle after reset

Ports:
clk_stream  in  1  clock
rst_stream  in  1  synchronous reset, active-high
start  in  1  pulse; launches or relaunches training
idelay_rdy  in  1  IDELAYCTRL ready, level, already synchronous to clk_stream
rx_valid  in  1  rx_data qualifier
rx_data  in  DATA_W  deserialised word
sel_clk_rst  out  1  SelectIO clock-buffer reset, active-high
sel_io_rst  out  1  ISERDES/IDELAY reset, active-high
bitslip  out  1  single-cycle bitslip pulse
busy  out  1  training in progress
locked  out  1  alignment achieved
fail  out  1  timeout or slip budget exhausted
slip_count  out  4  bitslips issued in the current attempt

Behaviour:
- All outputs are registered.
- Reset values: sel_clk_rst=1, sel_io_rst=1, bitslip=0, busy=0, locked=0, fail=0, slip_count=0, state IDLE. Reset has priority over everything, mid-operation included.
- States: IDLE, CLK_RST, IO_RST, WAIT_RDY, SETTLE, CHECK, SLIP, LOCKED, FAIL.
- Launch: goes to CLK_RST on a start pulse, or on the first post-reset cycle if AUTO_START=1.
- IDLE: both SelectIO resets held at 1, busy=0. Launch → CLK_RST.
- CLK_RST: sel_clk_rst=1, sel_io_rst=1, busy=1, slip_count=0, locked=0, fail=0. Lasts exactly CLK_RST_CYCLES cycles → IO_RST.
- IO_RST: sel_clk_rst=0, sel_io_rst=1. Lasts exactly IO_RST_CYCLES cycles → WAIT_RDY.
- WAIT_RDY: both resets 0. idelay_rdy=1 → SETTLE. RDY_TIMEOUT cycles without ready → FAIL.
- SETTLE: counts SETTLE_CYCLES; clears the match counter → CHECK. rx_data is ignored.
- CHECK: acts only on cycles with rx_valid=1.
  - Match: match counter +1; reaching MATCH_COUNT → LOCKED.
  - Mismatch: if slip_count < MAX_SLIPS → SLIP; else → FAIL.
  - rx_valid=0 leaves the counter unchanged.
- SLIP: bitslip=1 for exactly one cycle; slip_count +1 (saturates at 15) → SETTLE.
- LOCKED: locked=1, busy=0. Held until start or reset; mismatching data does not clear it.
- FAIL: fail=1, busy=0. Resets stay 0; held until start or reset.
- start in LOCKED or FAIL → CLK_RST: locked and fail clear and slip_count zeroes on entry.
- start while busy=1 is ignored.
- Start and a lock or fail event in the same cycle: the event wins; start is dropped.
- locked and fail are never 1 together. bitslip is never high in consecutive cycles.
- Counters are sized to the largest parameter they count and compare with equality; no wrap occurs.

Test Plan:
- AUTO_START=1, release rst_stream, idelay_rdy=1, rx_data=TRAIN_PATTERN with rx_valid every cycle →
  - sel_clk_rst falls 16 cycles after launch; sel_io_rst falls 8 cycles later;
  - locked=1 after settle (32) + 16 matches; slip_count=0; bitslip never pulses.
- rx_data is the pattern rotated left by 3 (3 bitslips correct it; bench model rotates on each bitslip) → exactly 3 single-cycle bitslip pulses, each followed by 32 idle cycles; locked=1, slip_count=3.
- rx_data constant 8'h00 → 8 bitslips, then fail=1, locked=0, slip_count=8, busy=0.
- idelay_rdy held 0 → fail=1 exactly 1024 cycles after entering WAIT_RDY; no bitslip is ever issued.
- While locked, pulse start → sel_clk_rst=1 next cycle, locked=0, slip_count=0, and the full sequence relocks. A start pulse during CHECK has no effect.
- Assert rst_stream during SLIP/CHECK → next cycle both SelectIO resets=1, bitslip=0, all status outputs 0.
- rx_valid toggling 1/0 → lock needs 16 valid matches, i.e. about 32 cycles in CHECK.
